// File: rtl/tube_r3_block_seq.sv
// Host-domain sequencer for Tube register 3 block transfers: mode flags, unit counting,
// host DMA request, parasite NMI and completion status.
module tube_r3_block_seq #(
    parameter int unsigned CNT_W     = 8,
    parameter logic [2:0]  CTRL_ADDR = 3'd0,
    parameter logic [2:0]  CNT_ADDR  = 3'd1
) (
    input  logic       h_phi2,
    input  logic       h_rst_b,
    input  logic       h_cs_b,
    input  logic       h_we_b,
    input  logic [2:0] h_addr,
    input  logic [7:0] h_data,
    output logic [7:0] h_rdata,
    input  logic       hp_h_full,
    input  logic       ph_h_avail,
    input  logic       hp_p_avail,
    input  logic       ph_p_full,
    output logic       one_byte_mode,
    output logic       h_drq,
    output logic       h_irq_b,
    output logic       p_nmi_b
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               v_q, v_d;
    logic               m_q, m_d;
    logic               dir_q, dir_d;
    logic               i_q, i_d;
    logic               done_q, done_d;
    logic               hf_q, hf_d;
    logic               ha_q, ha_d;

    logic               wr_en;
    logic               ctrl_wr;
    logic               cnt_wr;
    logic               abort;
    logic               hf_rise;
    logic               ha_fall;
    logic               run;
    logic               drain;
    logic [7:0]         cnt_rd;

    assign wr_en   = !h_cs_b && !h_we_b;
    assign ctrl_wr = wr_en && (h_addr == CTRL_ADDR);
    assign cnt_wr  = wr_en && (h_addr == CNT_ADDR);
    assign hf_rise = hp_h_full && !hf_q;
    assign ha_fall = !ph_h_avail && ha_q;
    assign run     = (state_q == StRun);
    assign drain   = (state_q == StDrain);
    // Changing direction or unit size under a live block leaves the count meaningless.
    assign abort   = ctrl_wr && (h_data[4] || h_data[2]) && (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        m_d     = m_q;
        dir_d   = dir_q;
        i_d     = i_q;
        done_d  = done_q;
        hf_d    = hp_h_full;
        ha_d    = ph_h_avail;

        if (cnt_wr) begin
            cnt_d   = h_data[CNT_W-1:0];
            state_d = StRun;
            done_d  = 1'b0;
        end else if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StRun: begin
                    if (dir_q ? hf_rise : ha_fall) begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            if (dir_q) begin
                                state_d = StDrain;
                            end else begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                StDrain: begin
                    if (!hp_h_full) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (ctrl_wr) begin
            if (h_data[4]) v_d   = h_data[7];
            if (h_data[3]) m_d   = h_data[7];
            if (h_data[2]) dir_d = h_data[7];
            if (h_data[1]) i_d   = h_data[7];
            if (!h_data[7] && h_data[0]) done_d = 1'b0;
        end
    end

    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            v_q     <= 1'b0;
            m_q     <= 1'b0;
            dir_q   <= 1'b0;
            i_q     <= 1'b0;
            done_q  <= 1'b0;
            hf_q    <= 1'b0;
            ha_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            m_q     <= m_d;
            dir_q   <= dir_d;
            i_q     <= i_d;
            done_q  <= done_d;
            hf_q    <= hf_d;
            ha_q    <= ha_d;
        end
    end

    generate
        if (CNT_W >= 8) begin : g_cnt_trunc
            assign cnt_rd = cnt_q[7:0];
        end else begin : g_cnt_ext
            assign cnt_rd = {{(8 - CNT_W){1'b0}}, cnt_q};
        end
    endgenerate

    assign one_byte_mode = v_q;
    assign h_drq         = run && (dir_q ? !hp_h_full : ph_h_avail);
    assign h_irq_b       = !(done_q && i_q);
    assign p_nmi_b       = !(m_q && (run || drain) && (dir_q ? hp_p_avail : !ph_p_full));

    always_comb begin
        h_rdata = 8'h00;
        if (h_addr == CTRL_ADDR) begin
            h_rdata = {run || drain, done_q, drain, v_q, m_q, dir_q, i_q, 1'b0};
        end else if (h_addr == CNT_ADDR) begin
            h_rdata = cnt_rd;
        end
    end

endmodule

// File: tb/tb_tube_r3_block_seq.sv
// Directed bench for tube_r3_block_seq: host reads push expected outputs into a queue,
// a monitor pops and compares whenever a read is presented to the DUT.
module tb_tube_r3_block_seq;

    localparam logic [2:0] CTRL = 3'd0;
    localparam logic [2:0] CNT  = 3'd1;

    logic       h_phi2 = 1'b1;
    logic       h_rst_b;
    logic       h_cs_b;
    logic       h_we_b;
    logic [2:0] h_addr;
    logic [7:0] h_data;
    logic [7:0] h_rdata;
    logic       hp_h_full;
    logic       ph_h_avail;
    logic       hp_p_avail;
    logic       ph_p_full;
    logic       one_byte_mode;
    logic       h_drq;
    logic       h_irq_b;
    logic       p_nmi_b;

    int errors = 0;
    int checks = 0;

    logic [11:0] exp_q[$];
    string       name_q[$];

    tube_r3_block_seq dut (
        .h_phi2        (h_phi2),
        .h_rst_b       (h_rst_b),
        .h_cs_b        (h_cs_b),
        .h_we_b        (h_we_b),
        .h_addr        (h_addr),
        .h_data        (h_data),
        .h_rdata       (h_rdata),
        .hp_h_full     (hp_h_full),
        .ph_h_avail    (ph_h_avail),
        .hp_p_avail    (hp_p_avail),
        .ph_p_full     (ph_p_full),
        .one_byte_mode (one_byte_mode),
        .h_drq         (h_drq),
        .h_irq_b       (h_irq_b),
        .p_nmi_b       (p_nmi_b)
    );

    always #5 h_phi2 = ~h_phi2;

    // Monitor: DUT state changes on negedge, so a read is sampled on the posedge.
    always @(posedge h_phi2) begin
        if (h_rst_b && !h_cs_b && h_we_b) begin
            logic [11:0] act;
            logic [11:0] exp;
            string       nm;
            act = {h_rdata, h_drq, h_irq_b, p_nmi_b, one_byte_mode};
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_read: got {rdata,drq,irq_b,nmi_b,obm}=%h, no expectation", act);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (act !== exp) begin
                    errors = errors + 1;
                    $display("FAIL %s: got rdata=%h drq=%b irq_b=%b nmi_b=%b obm=%b, want rdata=%h drq=%b irq_b=%b nmi_b=%b obm=%b",
                             nm, act[11:4], act[3], act[2], act[1], act[0],
                             exp[11:4], exp[3], exp[2], exp[1], exp[0]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge h_phi2);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        h_addr = a;
        h_data = d;
        h_cs_b = 1'b0;
        h_we_b = 1'b0;
        @(posedge h_phi2);
        #1;
        h_cs_b = 1'b1;
        h_we_b = 1'b1;
    endtask

    task automatic rd(input string nm, input logic [2:0] a, input logic [7:0] rdata,
                      input logic drq, input logic irqb, input logic nmib, input logic obm);
        h_addr = a;
        h_cs_b = 1'b0;
        h_we_b = 1'b1;
        name_q.push_back(nm);
        exp_q.push_back({rdata, drq, irqb, nmib, obm});
        @(posedge h_phi2);
        #1;
        h_cs_b = 1'b1;
    endtask

    task automatic pulse_avail();
        ph_h_avail = 1'b1;
        idle(1);
        ph_h_avail = 1'b0;
        idle(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        h_rst_b    = 1'b0;
        h_cs_b     = 1'b1;
        h_we_b     = 1'b1;
        h_addr     = 3'd0;
        h_data     = 8'h00;
        hp_h_full  = 1'b0;
        ph_h_avail = 1'b0;
        hp_p_avail = 1'b0;
        ph_p_full  = 1'b1;
        #12;
        h_rst_b = 1'b1;

        rd("reset_ctrl", CTRL, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        rd("reset_cnt",  CNT,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

        // Host->parasite, one-byte units, three units.
        wr(CTRL, 8'h9E);
        wr(CNT, 8'd3);
        rd("h2p_start", CTRL, 8'h9E, 1'b1, 1'b1, 1'b1, 1'b1);
        hp_p_avail = 1'b1;
        rd("h2p_nmi", CTRL, 8'h9E, 1'b1, 1'b1, 1'b0, 1'b1);
        hp_h_full = 1'b1;
        idle(1);
        rd("h2p_full1", CNT, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1);
        hp_h_full = 1'b0;
        idle(1);
        rd("h2p_empty1", CNT, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1);
        hp_h_full = 1'b1;
        idle(1);
        hp_h_full = 1'b0;
        idle(1);
        rd("h2p_cnt1", CNT, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
        hp_h_full = 1'b1;
        idle(1);
        rd("h2p_drain", CTRL, 8'hBE, 1'b0, 1'b1, 1'b0, 1'b1);
        hp_h_full = 1'b0;
        idle(1);
        rd("h2p_done", CTRL, 8'h5E, 1'b0, 1'b0, 1'b1, 1'b1);
        rd("h2p_cnt0", CNT, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        hp_p_avail = 1'b0;

        // Clear DONE only.
        wr(CTRL, 8'h01);
        rd("status_clr", CTRL, 8'h1E, 1'b0, 1'b1, 1'b1, 1'b1);

        // Parasite->host, two-byte units, PNMI enabled.
        wr(CTRL, 8'h14);
        wr(CTRL, 8'h8A);
        wr(CNT, 8'd2);
        rd("p2h_start", CTRL, 8'h8A, 1'b0, 1'b1, 1'b1, 1'b0);
        ph_p_full = 1'b0;
        rd("p2h_nmi", CTRL, 8'h8A, 1'b0, 1'b1, 1'b0, 1'b0);
        ph_h_avail = 1'b1;
        idle(1);
        rd("p2h_avail", CNT, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
        ph_h_avail = 1'b0;
        idle(1);
        rd("p2h_cnt1", CNT, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_avail();
        rd("p2h_done", CTRL, 8'h4A, 1'b0, 1'b0, 1'b1, 1'b0);

        // Length 0 means 256 units.
        wr(CNT, 8'd0);
        rd("wrap_start", CNT, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 255; k++) pulse_avail();
        rd("wrap_255_cnt", CNT,  8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        rd("wrap_255_run", CTRL, 8'h8A, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_avail();
        rd("wrap_done", CTRL, 8'h4A, 1'b0, 1'b0, 1'b1, 1'b0);

        // Abort by V write mid-block.
        wr(CNT, 8'd5);
        pulse_avail();
        rd("abort_cnt4", CNT, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0);
        wr(CTRL, 8'h10);
        rd("abort_idle", CTRL, 8'h0A, 1'b0, 1'b1, 1'b1, 1'b0);

        // Length write on the same edge as a counting edge.
        wr(CNT, 8'd3);
        ph_h_avail = 1'b1;
        idle(1);
        ph_h_avail = 1'b0;
        wr(CNT, 8'd7);
        rd("restart_cnt", CNT, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-block.
        h_rst_b = 1'b0;
        #2;
        h_rst_b = 1'b1;
        rd("midreset_ctrl", CTRL, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        rd("midreset_cnt",  CNT,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

        idle(2);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
